// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch responder: one outstanding request per PC, result held for decode behind valid/ready.
// Optional FETCH_ALIGN_CHECK_EN: misaligned PCs are not requested and come back as id_adel=1 with id_inst=0.
module inst_fetch_ctrl #(
  parameter logic [31:0] PC_INITIAL = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic        wait_stop_choke,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetchState_e;

  fetchState_e fetchState_q;
  logic [31:0] idPc_q;
  logic [31:0] idInst_q;
  logic        idValid_q;
  logic        idAdel_q;
  logic        misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = |pc[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // Data arriving together with the address acceptance skips WAIT entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchState_q <= IDLE;
      idPc_q       <= PC_INITIAL;
      idInst_q     <= '0;
      idValid_q    <= 1'b0;
      idAdel_q     <= 1'b0;
    end else begin
      case (fetchState_q)
        IDLE: fetchState_q <= REQ;
        REQ: begin
          if (misaligned) begin
            fetchState_q <= HOLD;
            idValid_q    <= 1'b1;
            idInst_q     <= '0;
            idPc_q       <= pc;
            idAdel_q     <= 1'b1;
          end else if (inst_addr_ok) begin
            if (inst_data_ok) begin
              fetchState_q <= HOLD;
              idValid_q    <= 1'b1;
              idInst_q     <= inst_rdata;
              idPc_q       <= pc;
              idAdel_q     <= 1'b0;
            end else begin
              fetchState_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (inst_data_ok) begin
            fetchState_q <= HOLD;
            idValid_q    <= 1'b1;
            idInst_q     <= inst_rdata;
            idPc_q       <= pc;
            idAdel_q     <= 1'b0;
          end
        end
        HOLD: begin
          if (id_ready) begin
            fetchState_q <= REQ;
            idValid_q    <= 1'b0;
          end
        end
        default: fetchState_q <= IDLE;
      endcase
    end
  end

  // PC register advances on the same edge decode takes the held word.
  assign wait_stop_choke = ~((fetchState_q == HOLD) && id_ready);
  assign inst_req        = (fetchState_q == REQ) && !misaligned;
  assign inst_addr       = pc;
  assign id_valid        = idValid_q;
  assign id_pc           = idPc_q;
  assign id_inst         = idInst_q;
  assign id_adel         = idAdel_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: transaction-level model checked every cycle plus directed literal checks.
module tb_inst_fetch_ctrl;

  localparam logic [31:0] PC_INIT = 32'hbfc00000;

  logic        clk;
  logic        rstN;
  logic        addrOk;
  logic        dataOk;
  logic        idReady;
  logic [31:0] rdataVal;
  logic        echo;
  logic        pcOverride;
  logic [31:0] pcForce;
  logic [31:0] pcReg;
  logic        runChecks;

  wire  [31:0] pc        = pcOverride ? pcForce : pcReg;
  wire  [31:0] instRdata = echo ? pc : rdataVal;

  logic        choke;
  logic        instReq;
  logic [31:0] instAddr;
  logic        idValid;
  logic [31:0] idPc;
  logic [31:0] idInst;
  logic        idAdel;

  int compared   = 0;
  int mismatched = 0;

  inst_fetch_ctrl #(.PC_INITIAL(PC_INIT)) dut (
    .clk             (clk),
    .rst_n           (rstN),
    .pc              (pc),
    .wait_stop_choke (choke),
    .inst_req        (instReq),
    .inst_addr       (instAddr),
    .inst_addr_ok    (addrOk),
    .inst_data_ok    (dataOk),
    .inst_rdata      (instRdata),
    .id_valid        (idValid),
    .id_ready        (idReady),
    .id_pc           (idPc),
    .id_inst         (idInst),
    .id_adel         (idAdel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic pcMisaligned;
`ifdef FETCH_ALIGN_CHECK_EN
  assign pcMisaligned = |pc[1:0];
`else
  assign pcMisaligned = 1'b0;
`endif

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic aok, input logic dok, input logic rdy);
    addrOk  = aok;
    dataOk  = dok;
    idReady = rdy;
  endtask

  // Transaction view: a fresh bubble after reset, then either requesting, awaiting data, or holding a word.
  logic        mdlFresh;
  logic        mdlOutstanding;
  logic        mdlHolding;
  logic [31:0] mdlPc;
  logic [31:0] mdlInst;
  logic        mdlAdel;
  logic        advance;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mdlFresh       = 1'b1;
      mdlOutstanding = 1'b0;
      mdlHolding     = 1'b0;
      mdlPc          = PC_INIT;
      mdlInst        = 32'h0;
      mdlAdel        = 1'b0;
      pcReg         <= PC_INIT;
    end else begin
      advance = mdlHolding && idReady;
      if (mdlFresh) begin
        mdlFresh = 1'b0;
      end else if (mdlHolding) begin
        if (idReady) mdlHolding = 1'b0;
      end else if (mdlOutstanding) begin
        if (dataOk) begin
          mdlOutstanding = 1'b0;
          mdlHolding     = 1'b1;
          mdlPc          = pc;
          mdlInst        = instRdata;
          mdlAdel        = 1'b0;
        end
      end else if (pcMisaligned) begin
        mdlHolding = 1'b1;
        mdlPc      = pc;
        mdlInst    = 32'h0;
        mdlAdel    = 1'b1;
      end else if (addrOk) begin
        if (dataOk) begin
          mdlHolding = 1'b1;
          mdlPc      = pc;
          mdlInst    = instRdata;
          mdlAdel    = 1'b0;
        end else begin
          mdlOutstanding = 1'b1;
        end
      end
      if (advance) pcReg <= pcReg + 32'd4;
    end
  end

  logic expReq;

  always @(negedge clk) begin
    if (rstN && runChecks) begin
      expReq = !mdlFresh && !mdlOutstanding && !mdlHolding && !pcMisaligned;
      checkFlag("cyc_valid", idValid, mdlHolding);
      checkFlag("cyc_req", instReq, expReq);
      checkFlag("cyc_choke", choke, !(mdlHolding && idReady));
      checkOutput("cyc_id_pc", idPc, mdlPc);
      checkOutput("cyc_id_inst", idInst, mdlInst);
      checkFlag("cyc_adel", idAdel, mdlAdel);
      if (expReq) checkOutput("cyc_addr", instAddr, pc);
    end
  end

  initial begin
    rstN       = 1'b1;
    rdataVal   = 32'h0;
    echo       = 1'b0;
    pcOverride = 1'b0;
    pcForce    = 32'h0;
    runChecks  = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1 rstN = 1'b0;
    #2;
    checkFlag("rst_req", instReq, 1'b0);
    checkFlag("rst_valid", idValid, 1'b0);
    checkFlag("rst_adel", idAdel, 1'b0);
    checkFlag("rst_choke", choke, 1'b1);
    checkOutput("rst_id_pc", idPc, PC_INIT);
    checkOutput("rst_id_inst", idInst, 32'h0);

    @(posedge clk); #1;
    rstN      = 1'b1;
    runChecks = 1'b1;
    echo      = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(posedge clk); #2;
    checkFlag("first_req", instReq, 1'b1);
    checkOutput("first_addr", instAddr, PC_INIT);

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      checkFlag("bb_valid", idValid, (i % 2) == 0);
      checkFlag("bb_choke", choke, (i % 2) != 0);
      if ((i % 2) == 0) begin
        checkOutput("bb_id_pc", idPc, PC_INIT + 32'(4 * (i / 2)));
        checkOutput("bb_id_inst", idInst, PC_INIT + 32'(4 * (i / 2)));
      end
    end

    echo     = 1'b0;
    rdataVal = 32'h1234_5678;
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkFlag("slow_req", instReq, 1'b1);
      checkOutput("slow_addr", instAddr, 32'hbfc0000c);
      if (i == 3) addrOk = 1'b1;
      @(posedge clk); #2;
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkFlag("wait_req", instReq, 1'b0);
    checkFlag("wait_valid", idValid, 1'b0);
    @(posedge clk); #2;
    checkFlag("wait2_valid", idValid, 1'b0);
    dataOk = 1'b1;
    @(posedge clk); #2;
    dataOk = 1'b0;
    checkFlag("slow_valid", idValid, 1'b1);
    checkOutput("slow_inst", idInst, 32'h1234_5678);
    checkOutput("slow_id_pc", idPc, 32'hbfc0000c);

    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(posedge clk); #2;
      end
      checkFlag("stall_valid", idValid, 1'b1);
      checkFlag("stall_choke", choke, 1'b1);
      checkOutput("stall_id_pc", idPc, 32'hbfc0000c);
      checkOutput("stall_inst", idInst, 32'h1234_5678);
      checkOutput("stall_pc", pc, 32'hbfc0000c);
    end
    idReady = 1'b1;
    #1;
    checkFlag("release_choke", choke, 1'b0);
    @(posedge clk); #1;
    checkOutput("pc_advance", pc, 32'hbfc00010);
    checkFlag("adv_req", instReq, 1'b1);
    checkOutput("adv_addr", instAddr, 32'hbfc00010);
    checkFlag("adv_valid", idValid, 1'b0);

    rdataVal = 32'hdead_beef;
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(posedge clk); #2;
    checkFlag("stray_req", instReq, 1'b1);
    checkFlag("stray_valid", idValid, 1'b0);
    checkOutput("stray_inst", idInst, 32'h1234_5678);
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(posedge clk); #2;
    checkFlag("wait3_req", instReq, 1'b0);
    addrOk = 1'b0;
    #2;
    rstN = 1'b0;
    #2;
    checkFlag("arst_req", instReq, 1'b0);
    checkFlag("arst_valid", idValid, 1'b0);
    checkFlag("arst_adel", idAdel, 1'b0);
    checkFlag("arst_choke", choke, 1'b1);
    checkOutput("arst_id_pc", idPc, PC_INIT);
    checkOutput("arst_id_inst", idInst, 32'h0);
    @(posedge clk); #1;
    rstN   = 1'b1;
    dataOk = 1'b1;
    @(posedge clk); #2;
    checkFlag("late_valid", idValid, 1'b0);
    checkFlag("late_req", instReq, 1'b1);
    @(posedge clk); #2;
    checkFlag("late2_valid", idValid, 1'b0);
    dataOk = 1'b0;

    pcOverride = 1'b1;
    pcForce    = 32'hbfc00002;
    idReady    = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    checkFlag("mis_req", instReq, 1'b0);
`else
    checkFlag("mis_req", instReq, 1'b1);
    checkOutput("mis_addr", instAddr, 32'hbfc00002);
`endif
    rdataVal = 32'hcafe_f00d;
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(posedge clk); #2;
    checkFlag("mis_valid", idValid, 1'b1);
    checkOutput("mis_id_pc", idPc, 32'hbfc00002);
`ifdef FETCH_ALIGN_CHECK_EN
    checkFlag("mis_adel", idAdel, 1'b1);
    checkOutput("mis_inst", idInst, 32'h0);
`else
    checkFlag("mis_adel", idAdel, 1'b0);
    checkOutput("mis_inst", idInst, 32'hcafe_f00d);
`endif

    pcOverride = 1'b0;
    echo       = 1'b1;
    idReady    = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    checkFlag("adel_cleared", idAdel, 1'b0);

    runChecks = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction-fetch responder that sits between the program counter register and the instruction SRAM-like port. It takes the current fetch PC, issues one request per PC, and waits for the data. It hands the fetched word to decode through a valid/ready register, and drives `wait_stop_choke` back to the PC register so the PC advances only when the current instruction has been consumed. Only one fetch is in flight at a time.

## Interface
Parameters:
- `PC_INITIAL`, 32'hbfc00000, reset value of `id_pc`; matches the PC register's reset vector.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous and active-low.
- `pc`  in  32  current fetch PC from the PC register.
- `wait_stop_choke`  out  1  1 = PC register holds; 0 = PC register advances by 4 at the next edge.
- `inst_req`  out  1  fetch request to instruction memory.
- `inst_addr`  out  32  request address; equals `pc` while `inst_req`=1.
- `inst_addr_ok`  in  1  memory accepted the request this cycle.
- `inst_data_ok`  in  1  read data valid this cycle.
- `inst_rdata`  in  32  read data.
- `id_valid`  out  1  fetched instruction is available to decode.
- `id_ready`  in  1  decode accepts the instruction this cycle.
- `id_pc`  out  32  PC of the held instruction.
- `id_inst`  out  32  held instruction word.
- `id_adel`  out  1  fetch address error flag; see Configuration.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: entered on reset. Drives no request. Goes to REQ on the next edge.
- REQ: `inst_req`=1, `inst_addr`=`pc`.
  - `inst_addr_ok`=1 and `inst_data_ok`=0: go to WAIT.
  - `inst_addr_ok`=1 and `inst_data_ok`=1: latch the data and go to HOLD.
  - `inst_addr_ok`=0: stay in REQ. Any `inst_data_ok` is ignored.
- WAIT: `inst_req`=0. On `inst_data_ok`, latch the data and go to HOLD.
- Latch action: `id_inst`<=`inst_rdata`, `id_pc`<=`pc`, `id_adel`<=0.
- HOLD: `id_valid`=1. On `id_ready`=1, go to REQ.
- `inst_data_ok` outside WAIT, and outside REQ with `inst_addr_ok` in the same cycle, is ignored.
- `wait_stop_choke` = ~(state==HOLD & `id_ready`), combinational. The PC advances exactly once per consumed instruction, at the hand-off edge.
- `id_inst` and `id_pc` are stable throughout HOLD and are updated only by the latch action.

## Timing
- Reset (async assert) values:
  - state=IDLE, `inst_req`=0, `id_valid`=0, `id_adel`=0.
  - `id_pc`=`PC_INITIAL`, `id_inst`=0.
  - `wait_stop_choke`=1.
- Reset release: first `inst_req` in the second cycle after deassertion (IDLE lasts one cycle).
- Latency: with `inst_data_ok` arriving k cycles after `inst_addr_ok` (k≥0), `id_valid` rises k+1 cycles after the `inst_addr_ok` cycle.
- Best case, memory answers in the request cycle and `id_ready` is held 1: one instruction per 2 cycles (REQ, HOLD).
- Reset mid-fetch (REQ or WAIT): return to IDLE immediately. A late `inst_data_ok` for the abandoned request arrives in IDLE or REQ without `inst_addr_ok` and is dropped. The memory side guarantees it does not coincide with a new `inst_addr_ok`.
- Downstream stall: HOLD is held indefinitely with outputs stable and `wait_stop_choke`=1.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - In REQ, if `pc[1:0]`!=0, the block drives `inst_req`=0.
  - In the same cycle it goes to HOLD with `id_inst`=0, `id_pc`=`pc` and `id_adel`=1. No memory transaction occurs.
  - `id_adel` clears on the next latch action.
- Not defined: no alignment check. `id_adel` is tied 0 and misaligned PCs are requested as-is.

## Test plan
- Reset then `inst_addr_ok`=`inst_data_ok`=1 always, `id_ready`=1, memory returns `addr`:
  - `id_pc` sequence is 0xbfc00000, 0xbfc00004, 0xbfc00008, with `id_valid` pulsing every 2nd cycle.
  - `wait_stop_choke` is low only in HOLD cycles.
- `inst_addr_ok` delayed 3 cycles, `inst_data_ok` 2 cycles after that:
  - `inst_req` stays high for 4 cycles with a constant `inst_addr`.
  - `id_valid` rises 3 cycles after `inst_addr_ok`, with `id_inst`=`inst_rdata`.
- `id_ready`=0 for 5 cycles in HOLD:
  - `id_inst` and `id_pc` stay stable and `wait_stop_choke` stays 1.
  - After `id_ready`=1, the PC advances by exactly 4.
- Assert `rst_n`=0 asynchronously while in WAIT, then inject a stray `inst_data_ok`:
  - Outputs reach their reset values without a clock edge.
  - The stray `inst_data_ok` produces no `id_valid`.
- `inst_data_ok` pulses while in REQ with `inst_addr_ok`=0: the pulse is ignored and the state stays REQ.
- With `FETCH_ALIGN_CHECK_EN`, force `pc`=0xbfc00002:
  - No `inst_req` is issued.
  - Decode sees `id_valid`=1, `id_adel`=1, `id_inst`=0.
  - Without the macro, `inst_addr`=0xbfc00002 is requested and `id_adel` stays 0.
